pad_th_sequencer: RTL
=====================

Name: pad_th_sequencer

Overview:
- Controller for one Genesis pad port. Snoops CPU writes to that port's data and control registers.
- Derives the effective TH line level and counts TH edges to produce the 3-bit protocol phase that the pad datapath muxes use to select button groups (3-button/6-button, including the X/Y/Z/MODE phase).
- Runs the 6-button inactivity timeout that returns the phase to 0.
- One instance per port, placed beside the I/O register block and sharing its CPU bus inputs.

Parameters:
- PORT_ADDR, 1, word address (A[4:1]) of this port's data register; the control register sits at PORT_ADDR+3.
- TIMEOUT, 11520, CE ticks without a TH edge before phase resets (≈1.5 ms at 7.67 MHz CE).
- TW, 14, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CE  in  1  I/O clock enable; qualifies register writes and timer decrement
- J3BUT  in  1  1 = 3-button mode: phase held at 0, timer idle
- SEL  in  1  I/O register block select
- A  in  4 (A[4:1])  register word address
- RNW  in  1  1 = read, 0 = write
- DI  in  8  CPU write data
- TH_OUT  out  1  effective TH level
- PHASE  out  3  protocol phase 0..7
- BUSY  out  1  1 while a 6-button sequence is active (timer running)

Behaviour:
- Write strobe: wr = SEL & ~RNW & CE.
  - wr & A==PORT_ADDR: data_reg <= DI.
  - wr & A==PORT_ADDR+3: ctrl_reg <= DI.
  - All other addresses are ignored. Reads have no effect.
- Effective TH: ctrl_reg[6] ? data_reg[6] : 1 (input direction = pulled high). TH_OUT is this value, taken directly from the registers.
  - A write on edge N is visible on TH_OUT after edge N.
- Edge detect: th_prev is registered every clock, independent of CE. edge = TH_OUT ^ th_prev. Both rising and falling edges count.
  - PHASE and BUSY update on the edge after TH_OUT changes: one-cycle lag behind TH_OUT.
- State machine, 2 states:
  - IDLE: PHASE=0, BUSY=0, timer not running.
    - edge & ~J3BUT → ACTIVE; PHASE <= 1; timer <= TIMEOUT.
  - ACTIVE: BUSY=1.
    - edge → PHASE <= PHASE+1 (modulo 8; 7 wraps to 0 and the state stays ACTIVE); timer <= TIMEOUT.
    - else CE & timer != 0 → timer <= timer-1.
    - else timer == 0 → IDLE, PHASE <= 0.
- Simultaneous edge and timer expiry: the edge wins (increment and reload).
- J3BUT high in any state: next cycle IDLE, PHASE=0, timer=0. Edges are ignored while J3BUT is high. th_prev still tracks TH_OUT, so a TH level present when J3BUT falls is not counted.
- Timer does not decrement on cycles with CE low. Expiry is checked on every clock.
- Reset values: data_reg=8'h00, ctrl_reg=8'h00, th_prev=1, timer=0, state IDLE, TH_OUT=1, PHASE=0, BUSY=0.
- Reset asserted mid-sequence returns everything to the reset values on the next edge. Reset has priority over writes in the same cycle.

Optional Feature:
- Macro TH_EDGE_STAT_EN.
- Defined:
  - Adds output EDGE_CNT [7:0], a free-running count of counted TH edges (edges taken while J3BUT=0).
  - Wraps 255→0. Reset to 0.
  - Updates in the same cycle as PHASE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then write ctrl(A=4)=8'h40, data(A=1)=8'h40 → TH_OUT=1. Then data=8'h00 → TH_OUT=0 next cycle; PHASE=1 one cycle later; BUSY=1.
- Toggle data bit6 seven more times with CE held high → PHASE steps 2,3,4,5,6,7,0; BUSY stays 1.
- TIMEOUT=16, CE every cycle, one edge then no writes → BUSY falls and PHASE=0 exactly 17 cycles after the edge's PHASE update. Repeat with CE every 4th cycle → expiry about 4× later.
- Edge written in the same cycle as timer==0 → PHASE increments, timer reloads to 16, state stays ACTIVE.
- J3BUT=1 during PHASE=3 → next cycle PHASE=0, BUSY=0; further TH toggles leave PHASE=0. Writes with ctrl bit6=0 force TH_OUT=1 regardless of data.
- Write to A=2 and A=5 (other port), and a read with RNW=1 at A=1 → no TH_OUT or PHASE change. With TH_EDGE_STAT_EN, 260 edges → EDGE_CNT=4.

Source files
------------

// File: rtl/pad_th_sequencer.sv
// TH edge sequencer for one pad port: snoops data/ctrl writes, tracks the 6-button phase and timeout.
// Optional TH_EDGE_STAT_EN adds an EDGE_CNT output counting the TH edges that advanced the phase.
module pad_th_sequencer #(
    parameter int PORT_ADDR = 1,
    parameter int TIMEOUT   = 11520,
    parameter int TW        = 14
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic       J3BUT,
    input  logic       SEL,
    input  logic [4:1] A,
    input  logic       RNW,
    input  logic [7:0] DI,
    output logic       TH_OUT,
    output logic [2:0] PHASE,
`ifdef TH_EDGE_STAT_EN
    output logic       BUSY,
    output logic [7:0] EDGE_CNT
`else
    output logic       BUSY
`endif
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [3:0]    DATA_ADDR = 4'(PORT_ADDR);
    localparam logic [3:0]    CTRL_ADDR = 4'(PORT_ADDR + 3);
    localparam logic [TW-1:0] RELOAD    = TW'(TIMEOUT);

    logic [7:0]    data_reg;
    logic [7:0]    ctrl_reg;
    logic          th_prev;
    logic          th_edge;
    logic          wr;
    state_t        state, state_d;
    logic [2:0]    phase, phase_d;
    logic [TW-1:0] timer, timer_d;

    assign wr = SEL & ~RNW & CE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_reg <= 8'h00;
            ctrl_reg <= 8'h00;
        end else begin
            if (wr && A == DATA_ADDR) data_reg <= DI;
            if (wr && A == CTRL_ADDR) ctrl_reg <= DI;
        end
    end

    // An input-direction TH pin reads back as pulled high.
    assign TH_OUT  = ctrl_reg[6] ? data_reg[6] : 1'b1;
    assign th_edge = TH_OUT ^ th_prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            th_prev <= 1'b1;
            state   <= IDLE;
            phase   <= 3'd0;
            timer   <= '0;
        end else begin
            th_prev <= TH_OUT;
            state   <= state_d;
            phase   <= phase_d;
            timer   <= timer_d;
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        timer_d = timer;
        if (J3BUT) begin
            state_d = IDLE;
            phase_d = 3'd0;
            timer_d = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (th_edge) begin
                        state_d = ACTIVE;
                        phase_d = 3'd1;
                        timer_d = RELOAD;
                    end
                end
                ACTIVE: begin
                    // An edge on the expiry cycle wins and keeps the sequence alive.
                    if (th_edge) begin
                        phase_d = phase + 3'd1;
                        timer_d = RELOAD;
                    end else if (CE && timer != '0) begin
                        timer_d = timer - TW'(1);
                    end else if (timer == '0) begin
                        state_d = IDLE;
                        phase_d = 3'd0;
                    end
                end
            endcase
        end
    end

    assign PHASE = phase;
    assign BUSY  = (state == ACTIVE);

`ifdef TH_EDGE_STAT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            EDGE_CNT <= 8'd0;
        end else if (th_edge && !J3BUT) begin
            EDGE_CNT <= EDGE_CNT + 8'd1;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{data_reg[7], data_reg[5:0], ctrl_reg[7], ctrl_reg[5:0]};

endmodule
